mult_seq_ctrl: RTL and testbench
================================

Name: mult_seq_ctrl

Overview:
Iterative shift-add sequencer for the MULTU datapath and owner of the HI/LO register pair. It takes a multiply request from the control unit and runs WIDTH add/shift iterations, one per cycle. It then writes the 2*WIDTH-bit product to HI/LO. While the operation is outstanding it stalls the CPU for any further MULTU, MFHI or MFLO.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  MULTU issued this cycle (decoded MultRegwrite).
op_a  input  WIDTH  multiplicand (rs).
op_b  input  WIDTH  multiplier (rt).
mf_req  input  1  MFHI or MFLO issued this cycle.
hi  output  WIDTH  HI register, upper product half.
lo  output  WIDTH  LO register, lower product half.
busy  output  1  multiply in progress.
done  output  1  one-cycle pulse after HI/LO are updated.
stall  output  1  hold PC and pipeline this cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0, counter=0, internal acc/multiplicand/multiplier=0. Reset mid-operation aborts the operation and discards the partial product; HI/LO read 0.
- States: IDLE and RUN. busy = (state==RUN), registered.
- IDLE, start=1 at edge k:
  - load mcand = zero-extended op_a (2*WIDTH bits), mplier = op_b, acc = 0, count = WIDTH.
  - go to RUN.
  - start is ignored while in RUN.
- RUN, each edge:
  - if mplier[0], acc += mcand, computed modulo 2^(2*WIDTH).
  - mcand <<= 1; mplier >>= 1; count -= 1.
- On the edge where count goes 1->0 (edge k+WIDTH):
  - hi = final acc[2W-1:W], lo = final acc[W-1:0], including this edge's addition.
  - state returns to IDLE; done is registered high for exactly the following cycle.
- Latency: start sampled at edge k gives HI/LO valid after edge k+WIDTH and busy low from that edge. Back-to-back MULTU can be accepted at edge k+WIDTH+1.
- stall = busy & (start | mf_req), combinational. The stalled instruction is re-presented each cycle until busy falls. It is then accepted, or for MFHI/MFLO it reads the new HI/LO.
- In IDLE, mf_req never stalls; hi/lo are directly readable.
- start and mf_req both high in IDLE (not produced by the decoder): start is accepted, stall=0, and hi/lo still show the old values that cycle.
- HI/LO change only on the completion edge or on reset; they hold the previous product throughout RUN.
- The product is unsigned, and all 2*WIDTH bits are exact with no overflow. For example, 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.

Optional Feature:
MULT_EARLY_EXIT_EN.
- Defined: in RUN, if the post-shift mplier is 0, this edge is the completion edge regardless of count, with HI/LO and done as above. Latency is 1 + index of the highest set bit of op_b, and 1 cycle when op_b=0.
- Undefined: always exactly WIDTH RUN cycles. Results are identical in both builds; only the timing of busy, done and stall differs.

Test Plan:
- Reset, then op_a=7, op_b=6, start for 1 cycle -> busy high for 32 cycles, then hi=0, lo=42 and a done pulse at cycle 33.
- op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 32 RUN cycles.
- mf_req held from cycle 3 of a MULTU -> stall=1 until busy falls, stall=0 the next cycle, and hi/lo show the new product. In IDLE, mf_req gives stall=0.
- Second start during RUN (op_a=2, op_b=3 while 5*5 runs) -> stall=1 and the start is ignored. After completion lo=25; the re-presented start is accepted and gives lo=6.
- rst_n pulsed low at RUN cycle 10 -> busy=0, hi=lo=0, done never pulses; a new start=1 then completes normally.
- With MULT_EARLY_EXIT_EN: op_b=0 -> done after 1 cycle with hi=lo=0. op_b=0x10 -> 5 RUN cycles. op_b=0x80000000 -> 32 RUN cycles. Without the macro, all three take 32 cycles.

Source files
------------

// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: MULTU request, HI/LO readback and stall handshake between the control unit and the multiply sequencer.
interface mult_seq_ctrl_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             mf_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;
  modport master (output start, op_a, op_b, mf_req, input hi, lo, busy, done, stall);
  modport slave  (input start, op_a, op_b, mf_req, output hi, lo, busy, done, stall);
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: iterative shift-add MULTU sequencer owning HI/LO; stalls MULTU/MFHI/MFLO while busy.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst_n,
  mult_seq_ctrl_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic [W2-1:0]    acc_q, acc_d, mcand_q, mcand_d, sum;
  logic [WIDTH-1:0] mplier_q, mplier_d, mplier_sh;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, fin;
  always_comb begin
    sum       = mplier_q[0] ? acc_q + mcand_q : acc_q;
    mplier_sh = mplier_q >> 1;
`ifdef MULT_EARLY_EXIT_EN
    fin       = (cnt_q == CNT_W'(1)) || (mplier_sh == '0);
`else
    fin       = cnt_q == CNT_W'(1);
`endif
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d  = RUN;
        busy_d   = 1'b1;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
        mplier_d = bus.op_b;
        cnt_d    = CNT_W'(WIDTH);
      end
    end else begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_sh;
      cnt_d    = fin ? '0 : cnt_q - CNT_W'(1);
      if (fin) begin
        // the product written here includes this edge's partial add
        hi_d    = sum[W2-1:WIDTH];
        lo_d    = sum[WIDTH-1:0];
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.mf_req);
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: table vectors, random products against an arithmetic model, and stall/reset corner sequences.
module tb_mult_seq_ctrl;
  localparam int WIDTH = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();
  mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [31:0] b);
    int l;
`ifdef MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) l = i + 1;
`else
    l = WIDTH;
`endif
    return l;
  endfunction
  task automatic wait_idle(output int n, output bit held);
    logic [31:0] h0, l0;
    h0 = bus.hi;
    l0 = bus.lo;
    n = 0;
    held = 1'b1;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.busy && (bus.hi !== h0 || bus.lo !== l0)) held = 1'b0;
    end
  endtask
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bit held;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_rise", 64'(bus.busy), 64'(1));
    wait_idle(n, held);
    chk("latency", 64'(n), 64'(exp_lat(b)));
    chk("hilo_hold", 64'(held), 64'(1));
    chk("product", {bus.hi, bus.lo}, {ehi, elo});
    chk("done_pulse", 64'(bus.done), 64'(1));
    @(negedge clk);
    chk("done_fall", 64'(bus.done), 64'(0));
  endtask
  initial begin
    int n;
    bit held, flag;
    logic [31:0] a, b;
    logic [63:0] p;
    tbl[0] = '{32'd7, 32'd6, 32'd0, 32'd42};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2] = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    tbl[3] = '{32'd3, 32'h10, 32'd0, 32'h30};
    tbl[4] = '{32'h12345678, 32'h80000000, 32'h091A2B3C, 32'h00000000};
    tbl[5] = '{32'hDEADBEEF, 32'd1, 32'd0, 32'hDEADBEEF};
    tbl[6] = '{32'h80000000, 32'd2, 32'd1, 32'd0};
    tbl[7] = '{32'h00010000, 32'h00010000, 32'd1, 32'd0};
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.mf_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, bus.busy, bus.done, bus.stall, 1'b0, bus.hi}, 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_mult(tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);
    // MFHI/MFLO held during a multiply stalls until busy falls, then reads the new product
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.mf_req = 1'b1;
    #1 chk("mf_stall", 64'(bus.stall), 64'(1));
    n = 0; flag = 1'b1;
    while (bus.busy && n < 100) begin
      @(negedge clk); n++;
      #1 if (bus.busy && !bus.stall) flag = 1'b0;
    end
    chk("mf_stall_held", 64'(flag), 64'(1));
    chk("mf_release", 64'(bus.stall), 64'(0));
    chk("mf_read", {bus.hi, bus.lo}, 64'd81);
    @(negedge clk);
    #1 chk("mf_idle", 64'(bus.stall), 64'(0));
    bus.start = 1'b1; bus.op_a = 32'd1; bus.op_b = 32'd1;
    #1 chk("start_mf_idle_stall", 64'(bus.stall), 64'(0));
    chk("start_mf_idle_old", {bus.hi, bus.lo}, 64'd81);
    @(negedge clk);
    bus.start = 1'b0; bus.mf_req = 1'b0;
    wait_idle(n, held);
    chk("start_mf_result", {bus.hi, bus.lo}, 64'd1);
    // a second MULTU during RUN is stalled, ignored, then accepted once idle
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd5; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd3;
    #1 chk("b2b_stall", 64'(bus.stall), 64'(1));
    n = 0; flag = 1'b1;
    while (bus.busy && n < 100) begin
      @(negedge clk); n++;
      #1 if (bus.busy && !bus.stall) flag = 1'b0;
    end
    chk("b2b_stall_held", 64'(flag), 64'(1));
    chk("b2b_release", 64'(bus.stall), 64'(0));
    chk("b2b_first", {bus.hi, bus.lo}, 64'd25);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_accept", 64'(bus.busy), 64'(1));
    wait_idle(n, held);
    chk("b2b_second", {bus.hi, bus.lo}, 64'd6);
    // reset mid-operation discards the product and suppresses done
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 32'd11; bus.op_b = 32'hFFFF0000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) flag = 1'b0;
    end
    chk("rst_no_done", 64'(flag), 64'(1));
    run_mult(32'd123, 32'd456, 32'd0, 32'd56088);
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      p = 64'(a) * 64'(b);
      run_mult(a, b, p[63:32], p[31:0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
